// File: rtl/permutation_ctrl_pkg.sv
// Shared types and constants for the ASCON permutation sequencer.
package permutation_ctrl_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} type_perm_state_e;

    localparam int unsigned MAX_ROUNDS_C = 12;
    localparam int unsigned ROUNDS_PA_C  = 12;
    localparam int unsigned ROUNDS_PB_C  = 8;

    function automatic logic rounds_legal(input int unsigned rounds, input int unsigned max_rounds);
        return (rounds != 0) && (rounds <= max_rounds);
    endfunction

endpackage

// File: rtl/permutation_ctrl_if.sv
// Handshake with the mode FSM plus the control lines toward the permutation datapath.
interface permutation_ctrl_if #(
    parameter int unsigned ROUND_W = 4
) ();
    logic               start_i;
    logic [ROUND_W-1:0] rounds_i;
    logic               abort_i;
    logic               ready_o;
    logic               init_o;
    logic               enable_o;
    logic [ROUND_W-1:0] round_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    modport master (
        output start_i, rounds_i, abort_i,
        input  ready_o, init_o, enable_o, round_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, rounds_i, abort_i,
        output ready_o, init_o, enable_o, round_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/permutation_ctrl_round_counter.sv
// Loadable up-counter; terminal count compares against a last value latched at load time.
module permutation_ctrl_round_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] last_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            count_q <= '0;
            last_q  <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
            last_q  <= last_val_i;
        end else if (inc_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == last_q);
endmodule

// File: rtl/permutation_ctrl.sv
// Sequences the ASCON permutation datapath: one round per clock, Moore outputs only.
module permutation_ctrl
    import permutation_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_C,
    parameter int unsigned ROUND_W    = 4
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    permutation_ctrl_if.slave bus
);
    type_perm_state_e state_q, state_d;
    logic             init_q, init_d;
    logic             err_q, err_d;
    logic             load, inc, tc, legal;
    logic [ROUND_W-1:0] count;
    logic [ROUND_W-1:0] load_val;

    assign legal    = rounds_legal(32'(bus.rounds_i), MAX_ROUNDS);
    // Shorter permutations run the tail of the schedule so they always end on round MAX_ROUNDS-1.
    assign load_val = ROUND_W'(MAX_ROUNDS) - bus.rounds_i;

    permutation_ctrl_round_counter #(
        .WIDTH(ROUND_W)
    ) u_round_counter (
        .clock_i   (clock_i),
        .resetb_i  (resetb_i),
        .load_i    (load),
        .load_val_i(load_val),
        .last_val_i(ROUND_W'(MAX_ROUNDS - 1)),
        .inc_i     (inc),
        .count_o   (count),
        .tc_o      (tc)
    );

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q <= StIdle;
            init_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        inc     = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone && bus.abort_i) begin
                    state_d = StIdle;
                end else if (bus.start_i && legal) begin
                    load    = 1'b1;
                    init_d  = 1'b1;
                    state_d = StRun;
                end else begin
                    err_d   = bus.start_i;
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (bus.abort_i) begin
                    state_d = StIdle;
                end else if (tc) begin
                    state_d = StDone;
                end else begin
                    inc = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy_o   = (state_q == StRun);
        bus.enable_o = (state_q == StRun);
        bus.ready_o  = (state_q != StRun);
        bus.init_o   = (state_q == StRun) && init_q;
        bus.round_o  = (state_q == StRun) ? count : '0;
        bus.done_o   = (state_q == StDone);
        bus.err_o    = err_q;
    end
endmodule

// File: tb/tb_permutation_ctrl.sv
// Random and directed stimulus checked against a round-schedule queue model.
module tb_permutation_ctrl;
    import permutation_ctrl_pkg::*;

    logic clk;
    logic resetb;
    int   checks;
    int   errors;

    // Model: rounds still to be shown, the current one at the front.
    int   sched_q[$];
    logic exp_init;
    logic exp_done;
    logic exp_err;

    permutation_ctrl_if #(.ROUND_W(4)) bus ();

    permutation_ctrl #(
        .MAX_ROUNDS(MAX_ROUNDS_C),
        .ROUND_W   (4)
    ) dut (
        .clock_i (clk),
        .resetb_i(resetb),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic s, input int r, input logic a, input logic rb);
        if (!rb) begin
            sched_q.delete();
            exp_init = 1'b0;
            exp_done = 1'b0;
            exp_err  = 1'b0;
        end else if (sched_q.size() > 0) begin
            exp_err = 1'b0;
            if (a) begin
                sched_q.delete();
                exp_done = 1'b0;
            end else begin
                void'(sched_q.pop_front());
                exp_done = (sched_q.size() == 0);
            end
            exp_init = 1'b0;
        end else begin
            exp_init = 1'b0;
            exp_err  = 1'b0;
            if (exp_done && a) begin
                exp_done = 1'b0;
            end else if (s && r >= 1 && r <= 12) begin
                for (int k = 12 - r; k < 12; k++) sched_q.push_back(k);
                exp_init = 1'b1;
                exp_done = 1'b0;
            end else begin
                exp_err  = s;
                exp_done = 1'b0;
            end
        end
    endtask

    task automatic step(input logic s, input int r, input logic a, input logic rb);
        logic running;
        @(negedge clk);
        bus.start_i  = s;
        bus.rounds_i = 4'(r);
        bus.abort_i  = a;
        resetb       = rb;
        @(posedge clk);
        #1;
        model_edge(s, r, a, rb);
        running = (sched_q.size() > 0);
        check("ready", int'(bus.ready_o), int'(!running));
        check("busy", int'(bus.busy_o), int'(running));
        check("enable", int'(bus.enable_o), int'(running));
        check("init", int'(bus.init_o), int'(exp_init));
        check("round", int'(bus.round_o), running ? sched_q[0] : 0);
        check("done", int'(bus.done_o), int'(exp_done));
        check("err", int'(bus.err_o), int'(exp_err));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_init     = 1'b0;
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        resetb       = 1'b0;
        bus.start_i  = 1'b0;
        bus.rounds_i = '0;
        bus.abort_i  = 1'b0;

        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 12, 1'b1, 1'b0);
        // Full pa run, then pb run with back-to-back pb-6 start in its DONE cycle.
        step(1'b1, int'(ROUNDS_PA_C), 1'b0, 1'b1);
        repeat (13) step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, int'(ROUNDS_PB_C), 1'b0, 1'b1);
        repeat (8) step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 6, 1'b0, 1'b1);
        repeat (7) step(1'b0, 0, 1'b0, 1'b1);
        // Illegal round counts.
        step(1'b1, 0, 1'b0, 1'b1);
        step(1'b1, 13, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        // Abort at round 5, then restart.
        step(1'b1, 12, 1'b0, 1'b1);
        repeat (5) step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b1, 12, 1'b0, 1'b1);
        repeat (3) step(1'b0, 0, 1'b0, 1'b1);
        // Reset mid-run with start held high.
        step(1'b1, 12, 1'b0, 1'b0);
        step(1'b1, 12, 1'b0, 1'b1);
        repeat (13) step(1'b0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            int   r;
            logic s, a, rb;
            rb = ($urandom_range(0, 199) != 0);
            a  = ($urandom_range(0, 29) == 0);
            s  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       r = 12;
                1:       r = 8;
                2:       r = 6;
                default: r = int'($urandom_range(0, 15));
            endcase
            step(s, r, a, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/permutation_ctrl.md
Name: permutation_ctrl

Overview:
- Sequencer for the ASCON permutation datapath (state mux, pC/pS/pL, state register).
- Accepts a start request with a round count, then drives the datapath's init select, register enable and 4-bit round index for the required number of cycles, one round per clock.
- Signals completion when the permutated state is valid in the register.
- Sits between the AEAD mode FSM (requester) and the permutation datapath.

Parameters:
- MAX_ROUNDS, 12, rounds in a full pa permutation; the last round index is MAX_ROUNDS-1.
- ROUND_W, 4, width of the round index and round-count fields.

Ports:
- clock_i, in, 1, system clock; all state updates on the rising edge.
- resetb_i, in, 1, synchronous active-low reset.
- start_i, in, 1, request to run a permutation; accepted only when ready_o=1.
- rounds_i, in, ROUND_W, number of rounds requested (legal: 1..12; the mode FSM uses 12, 8, 6); sampled on accept.
- abort_i, in, 1, synchronous abort; returns to IDLE next edge.
- ready_o, out, 1, controller can accept start_i this cycle.
- init_o, out, 1, to datapath init: selects the external state into the round logic.
- enable_o, out, 1, to datapath register enable.
- round_o, out, ROUND_W, to datapath round index for the round constant.
- busy_o, out, 1, a permutation is in progress.
- done_o, out, 1, one-cycle pulse: the datapath register holds the result.
- err_o, out, 1, one-cycle pulse: start rejected because rounds_i is illegal.

Behaviour:
- Reset (resetb_i=0 at an edge): state=IDLE, round counter=0. Outputs: ready_o=1, busy_o=0, init_o=0, enable_o=0, done_o=0, err_o=0, round_o=0.
- Reset dominates abort_i and start_i. Reset mid-run abandons the run with no done_o.
- All outputs are decoded from registered state (Moore); no combinational path from inputs to outputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1; enable_o=0.
  - start_i=1 with rounds_i in 1..MAX_ROUNDS: latch last=MAX_ROUNDS-1, load counter with MAX_ROUNDS-rounds_i, go to RUN.
  - start_i=1 with rounds_i=0 or >MAX_ROUNDS: stay in IDLE, err_o=1 on the next cycle.
- RUN:
  - enable_o=1, busy_o=1, ready_o=0, round_o=counter.
  - init_o=1 only in the first RUN cycle (first round takes the external state); 0 in later rounds.
  - Counter increments by 1 each cycle.
  - When counter==last, go to DONE next edge.
  - Round indices for 12 rounds: 0..11. For 8 rounds: 4..11. For 6 rounds: 6..11.
- DONE:
  - done_o=1, enable_o=0 (result held), ready_o=1, busy_o=0.
  - start_i accepted here exactly as in IDLE, giving back-to-back operation; with no start, go to IDLE.
- Latency: start accepted at edge t; rounds occupy cycles t+1..t+N; done_o high in cycle t+N+1. Total N+1 cycles to done.
- abort_i=1 in RUN or DONE: next state IDLE, enable_o=0 the following cycle, no done_o. Register contents are undefined to the user.
- abort_i and start_i together in DONE: abort wins, start is dropped.
- start_i while busy (RUN): ignored, not queued.
- Counter never wraps: a counter equal to last always exits RUN. No counter value above MAX_ROUNDS-1 is reachable.

Decomposition:
- ascon_pack additions:
  - enum type_perm_state {IDLE, RUN, DONE}.
  - constant MAX_ROUNDS_C=12.
  - constants ROUNDS_PA_C=12, ROUNDS_PB_C=8.
- Sub-module round_counter (loadable 4-bit up-counter with load value, enable and terminal-count flag against a latched last value).
- permutation_ctrl instantiates round_counter plus the FSM.
- A wrapper pairs permutation_ctrl with the permutation datapath.

Test Plan:
- Reset then start_i=1, rounds_i=12 → RUN 12 cycles with round_o 0,1,..,11. init_o=1 only with round_o=0. done_o pulse in cycle 13. ready_o=0 throughout RUN.
- rounds_i=8 → round_o 4..11. done_o 9 cycles after accept. With the datapath connected, the register matches the ASCON reference pb output for a known input state.
- Back-to-back: start in the DONE cycle with rounds_i=6 → round_o 6..11 begins the next cycle, init_o=1 at round 6, no IDLE cycle in between.
- rounds_i=0 and rounds_i=13 → err_o pulses once each, stays IDLE, enable_o never asserts.
- abort_i at round_o=5 of a 12-round run → IDLE next cycle, enable_o=0, no done_o. A new start then runs correctly from round 0.
- resetb_i=0 at round 3, start_i held high → all outputs return to reset values at that edge. After release, start is accepted with the standard latency.
